muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Sequential MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on magnitudes, with sign fix-up in a final cycle.
// Optional macro MULDIV_DIVZERO_FLAG_EN adds a registered divide-by-zero flag output.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q;
  logic               qneg_q;   // product / quotient must be negated
  logic               rneg_q;   // remainder must be negated
  logic [2*WIDTH-1:0] acc_q;    // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   b_q;      // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, res_hi, res_lo;
  logic               dz;

  // Operand magnitudes at latch time; op[0]=1 selects the unsigned variants.
  always_comb begin
    s1   = ~op[0] & data1[WIDTH-1];
    s2   = ~op[0] & data2[WIDTH-1];
    mag1 = s1 ? (~data1 + 1'b1) : data1;
    mag2 = s2 ? (~data2 + 1'b1) : data2;
  end

  // One multiply or divide iteration on the accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes; a zero divisor forces an all-ones quotient
  // and leaves the dividend (re-signed) as remainder.
  always_comb begin
    dz       = is_div_q & (b_q == '0);
    prod_fix = qneg_q ? (~acc_q + 1'b1) : acc_q;
    q_fix    = qneg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    r_fix    = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_hi = r_fix;
      res_lo = dz ? '1 : q_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

`ifdef MULDIV_DIVZERO_FLAG_EN
  logic div_zero_q;

  // Flag accompanies the done pulse of a divide by zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= (state_q == StFix) & dz;
    end
  end

  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  // Control FSM with datapath registers and registered HI/LO/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            is_div_q <= op[1];
            qneg_q   <= s1 ^ s2;
            rneg_q   <= s1;
            acc_q    <= op[1] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
            b_q      <= op[1] ? mag2 : mag1;
            cnt_q    <= CntInit;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
